// File: rtl/groestl_pkg.sv
// Shared Groestl-1024 primitives: AES S-box, GF(2^8) helpers, MixBytes column
// transform, the Q-side shift offsets and the column-major byte indexing.
package groestl_pkg;

  localparam int STATE_W = 1024;
  localparam int ROWS    = 8;
  localparam int COLS    = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } q_state_e;

  // ShiftBytes-Q rotation per row: row r reads from column (c + SIGMA_Q[r]) mod 16
  localparam int SIGMA_Q [ROWS] = '{1, 3, 5, 11, 0, 2, 4, 6};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  // Multiply by x (0x02) modulo 0x11B
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int byte_idx(input int row, input int col);
    return 8 * col + row;
  endfunction

  // One output byte: dot product of a row-rotated column with (02,02,03,04,05,03,05,07)
  function automatic logic [7:0] mix_dot(input logic [63:0] v);
    logic [7:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [7:0] x2, x3, x4, x5a, x5b, x3b, x7;
    a0 = v[63:56]; a1 = v[55:48]; a2 = v[47:40]; a3 = v[39:32];
    a4 = v[31:24]; a5 = v[23:16]; a6 = v[15:8];  a7 = v[7:0];
    x2  = gf_mul2(a0 ^ a1);
    x3  = gf_mul2(a2) ^ a2;
    x4  = gf_mul2(gf_mul2(a3));
    x5a = gf_mul2(gf_mul2(a4)) ^ a4;
    x3b = gf_mul2(a5) ^ a5;
    x5b = gf_mul2(gf_mul2(a6)) ^ a6;
    x7  = gf_mul2(gf_mul2(a7)) ^ gf_mul2(a7) ^ a7;
    return x2 ^ x3 ^ x4 ^ x5a ^ x3b ^ x5b ^ x7;
  endfunction

  // Column packed with row 0 in the top byte; output row i uses the column rotated up by i
  function automatic logic [63:0] mix_col(input logic [63:0] col);
    logic [63:0] res;
    logic [63:0] rot;
    res = '0;
    for (int i = 0; i < ROWS; i++) begin
      rot = (col << (8 * i)) | (col >> (64 - 8 * i));
      res = {res[55:0], mix_dot(rot)};
    end
    return res;
  endfunction

endpackage

// File: rtl/permutation_q_round.sv
// One combinational Groestl-1024 Q round: AddRoundConstant-Q, SubBytes,
// ShiftBytes-Q and MixBytes applied to the full column-major state.
module permutation_q_round
  import groestl_pkg::*;
(
  input  logic [STATE_W-1:0] state,
  input  logic [3:0]         rnd,
  output logic [STATE_W-1:0] next_state
);

  logic [7:0] sb [ROWS][COLS];

  for (genvar c = 0; c < COLS; c++) begin : g_col
    logic [63:0] pre_mix;
    logic [63:0] post_mix;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam int         K   = byte_idx(r, c);
      localparam int         SRC = (c + SIGMA_Q[r]) % COLS;
      localparam logic [3:0] C4  = 4'(c);
      logic [7:0] rc;

      // Only the bottom row carries the column/round dependent part of the constant
      if (r == ROWS - 1) begin : g_rc_last
        assign rc = 8'hff ^ {C4, rnd};
      end else begin : g_rc_ff
        assign rc = 8'hff;
      end

      assign sb[r][c] = sbox(state[STATE_W-1-8*K -: 8] ^ rc);
      assign pre_mix[63-8*r -: 8] = sb[r][SRC];
      assign next_state[STATE_W-1-8*K -: 8] = post_mix[63-8*r -: 8];
    end

    assign post_mix = mix_col(pre_mix);
  end

endmodule

// File: rtl/permutation_q_iter.sv
// Iterative Groestl-1024 permutation Q: one round per clock with a
// start/ready/done handshake; the result is held until the next start.
module permutation_q_iter
  import groestl_pkg::*;
#(
  parameter int ROUNDS = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] in,
  output logic               ready,
  output logic               done,
  output logic [STATE_W-1:0] out
);

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);

  q_state_e           fsm_q, fsm_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [STATE_W-1:0] out_q, out_d;
  logic               done_q, done_d;
  logic [STATE_W-1:0] round_out;

  permutation_q_round u_round (
    .state      (state_q),
    .rnd        (rnd_q),
    .next_state (round_out)
  );

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    out_d   = out_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          state_d = in;
          rnd_d   = 4'd0;
          fsm_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        state_d = round_out;
        rnd_d   = rnd_q + 4'd1;
        if (rnd_q == LAST_RND) begin
          out_d  = round_out;
          done_d = 1'b1;
          rnd_d  = 4'd0;
          fsm_d  = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q  <= ST_IDLE;
      rnd_q  <= 4'd0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      fsm_q  <= fsm_d;
      rnd_q  <= rnd_d;
      done_q <= done_d;
      out_q  <= out_d;
    end
  end

  // Working state is pure data: a reset only needs to discard it via the FSM
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign ready = (fsm_q == ST_IDLE);
  assign done  = done_q;
  assign out   = out_q;

endmodule

// File: tb/tb_permutation_q_iter.sv
// Scoreboard bench for permutation_q_iter plus direct checks of the round unit.
module tb_permutation_q_iter;

  localparam int ROUNDS = 14;
  localparam int SIG [8] = '{1, 3, 5, 11, 0, 2, 4, 6};
  localparam logic [7:0] MC [8] = '{8'h02, 8'h02, 8'h03, 8'h04, 8'h05, 8'h03, 8'h05, 8'h07};

  logic          clk;
  logic          reset;
  logic          start;
  logic [1023:0] in;
  logic          ready;
  logic          done;
  logic [1023:0] out;

  logic [1023:0] rs;
  logic [3:0]    rr;
  logic [1023:0] rn;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  logic [1023:0] exp_q [$];
  int            done_cyc [$];
  logic [7:0]    sb_tab [256];

  permutation_q_iter #(.ROUNDS(ROUNDS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .in    (in),
    .ready (ready),
    .done  (done),
    .out   (out)
  );

  permutation_q_round u_rnd (
    .state      (rs),
    .rnd        (rr),
    .next_state (rn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    logic [1023:0] g, e;
    int w;
    n_total++;
    if (got !== exp) begin
      n_bad++;
      g = got; e = exp; w = 0;
      while (g[1023:960] === e[1023:960] && w < 15) begin
        g = g << 64; e = e << 64; w++;
      end
      $display("FAIL %s word%0d got=%h want=%h", tag, w, g[1023:960], e[1023:960]);
    end
  endtask

  // Reference field arithmetic, S-box derived from inversion + affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_ref(input logic [7:0] v);
    logic [7:0] inv, s, r;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, v);
    s = inv; r = inv;
    for (int i = 0; i < 4; i++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [1023:0] q_round_ref(input logic [1023:0] v, input int rnd);
    logic [7:0]    a [8][16];
    logic [7:0]    t [8][16];
    logic [7:0]    c, acc;
    logic [1023:0] w;
    w = v;
    for (int k = 0; k < 128; k++) begin
      a[k % 8][k / 8] = w[1023:1016];
      w = w << 8;
    end
    for (int row = 0; row < 8; row++)
      for (int col = 0; col < 16; col++) begin
        c = 8'hff;
        if (row == 7) c = c ^ {4'(col), 4'(rnd)};
        t[row][col] = sb_tab[a[row][col] ^ c];
      end
    for (int row = 0; row < 8; row++)
      for (int col = 0; col < 16; col++)
        a[row][col] = t[row][(col + SIG[row]) % 16];
    for (int col = 0; col < 16; col++)
      for (int i = 0; i < 8; i++) begin
        acc = 8'h00;
        for (int j = 0; j < 8; j++) acc = acc ^ gmul(MC[(j - i + 8) % 8], a[j][col]);
        t[i][col] = acc;
      end
    w = '0;
    for (int k = 0; k < 128; k++) w = {w[1015:0], t[k % 8][k / 8]};
    return w;
  endfunction

  function automatic logic [1023:0] q_model(input logic [1023:0] v);
    logic [1023:0] s;
    s = v;
    for (int r = 0; r < ROUNDS; r++) s = q_round_ref(s, r);
    return s;
  endfunction

  function automatic logic [1023:0] rand_state();
    logic [1023:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) v = {v[991:0], 32'($urandom())};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(tag, done, 1'b1);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && done === 1'b1) begin
      done_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("done_without_start", done, 1'b0);
      else chk("result", out, exp_q.pop_front());
    end
  end

  initial begin
    logic [1023:0] va, vb, r0;
    int cnt, n0;

    for (int i = 0; i < 256; i++) sb_tab[i] = sbox_ref(8'(i));
    reset = 1'b1; start = 1'b0; in = '0; rs = '0; rr = 4'd0;

    // reset and idle hold
    tick(); tick();
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out, '0);
    reset = 1'b0;
    repeat (20) tick();
    chk("idle_ready", ready, 1'b1);
    chk("idle_out", out, '0);
    chk("idle_no_done", done_cyc.size(), 0);

    // single permutation of the all-zero state
    in = '0; start = 1'b1; exp_q.push_back(q_model('0));
    tick();
    start = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("busy_cycles", cnt, 14);
    chk("done_when_ready", done, 1'b1);
    r0 = q_model('0);
    repeat (10) begin
      tick();
      chk("hold_out", out, r0);
      chk("hold_done", done, 1'b0);
    end

    // round unit alone
    rs = '0; rr = 4'd0; #1;
    chk("rnd_sb_r0c0", u_rnd.sb[0][0], 8'h16);
    chk("rnd_sb_r3c9", u_rnd.sb[3][9], 8'h16);
    chk("rnd_sb_r7c0", u_rnd.sb[7][0], 8'h16);
    chk("rnd_sb_r7c1", u_rnd.sb[7][1], 8'hdf);
    chk("rnd_zero_full", rn, q_round_ref('0, 0));
    rs = rand_state(); rr = 4'd9; #1;
    chk("rnd_rand_r9", rn, q_round_ref(rs, 9));
    rs = rand_state(); rr = 4'd15; #1;
    chk("rnd_rand_r15", rn, q_round_ref(rs, 15));

    // back-to-back with start held high
    va = rand_state(); vb = rand_state();
    in = va; start = 1'b1; exp_q.push_back(q_model(va));
    tick();
    cnt = 0;
    while (done !== 1'b1 && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("b2b_first_done", done, 1'b1);
    in = vb; exp_q.push_back(q_model(vb));
    tick();
    start = 1'b0;
    wait_done("b2b_second_done");
    chk("b2b_period", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], ROUNDS + 1);

    // start while busy is ignored
    va = rand_state(); vb = rand_state();
    n0 = done_cyc.size();
    tick();
    in = va; start = 1'b1; exp_q.push_back(q_model(va));
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("busy_ready_c3", ready, 1'b0);
    in = vb; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("busy_ready_c9", ready, 1'b0);
    in = rand_state(); start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("busy_done");
    repeat (20) tick();
    chk("busy_one_done", done_cyc.size() - n0, 1);

    // reset during round 7
    va = rand_state();
    in = va; start = 1'b1; exp_q.push_back(q_model(va));
    tick();
    start = 1'b0;
    repeat (7) tick();
    reset = 1'b1; exp_q.delete();
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_out", out, '0);
    n0 = done_cyc.size();
    repeat (20) tick();
    chk("mid_rst_no_done", done_cyc.size() - n0, 0);
    vb = rand_state();
    in = vb; start = 1'b1; exp_q.push_back(q_model(vb));
    tick();
    start = 1'b0;
    wait_done("post_rst_done");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
